// File: rtl/alu_exec_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_exec_pkg
//  Description : Shared definitions for the execute stage. This package holds
//                the 4-bit ALU operation codes and the default datapath width.
//  Revision    : 1.0  initial release
// ============================================================================
package alu_exec_pkg;

    localparam int XLEN_DEFAULT = 32;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_NOR  = 4'd5;
    localparam logic [3:0] ALU_SLT  = 4'd6;
    localparam logic [3:0] ALU_SLTU = 4'd7;
    localparam logic [3:0] ALU_SLL  = 4'd8;
    localparam logic [3:0] ALU_SRL  = 4'd9;
    localparam logic [3:0] ALU_SRA  = 4'd10;
    localparam logic [3:0] ALU_LUI  = 4'd11;
    localparam logic [3:0] ALU_MUL  = 4'd12;
    localparam logic [3:0] ALU_PASS = 4'd13;

endpackage : alu_exec_pkg
`default_nettype wire

// File: rtl/alu_exec_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : alu_exec_unit_if
//  Description : Bundles the execute-stage operands, controls and results.
//                master : the side that issues operands and reads results
//                slave  : the execute unit
//  Revision    : 1.0  initial release
// ============================================================================
interface alu_exec_unit_if
    import alu_exec_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
);
    logic            valid_in;
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] rs_data;
    logic [XLEN-1:0] rt_data;
    logic [XLEN-1:0] pc_incremented;
    logic            alu_src;
    logic            is_unsigned;
    logic            does_shift_amount_need;
    logic [3:0]      alu_operation;
    logic [XLEN-1:0] result;
    logic            zero;
    logic            negative;
    logic [XLEN-1:0] branch_target;
    logic            valid_out;

    modport master (
        output valid_in, inst, rs_data, rt_data, pc_incremented,
               alu_src, is_unsigned, does_shift_amount_need, alu_operation,
        input  result, zero, negative, branch_target, valid_out
    );

    modport slave (
        input  valid_in, inst, rs_data, rt_data, pc_incremented,
               alu_src, is_unsigned, does_shift_amount_need, alu_operation,
        output result, zero, negative, branch_target, valid_out
    );
endinterface : alu_exec_unit_if
`default_nettype wire

// File: rtl/alu_core.sv
`default_nettype none
// ============================================================================
//  Module      : alu_core
//  Description : Purely combinational ALU with zero/negative flags.
//                input1, input2 : operands
//                alu_operation  : 4-bit op code
//                out            : result (mod 2^XLEN)
//                zero, negative : flags derived from out
//  Revision    : 1.0  initial release
// ============================================================================
module alu_core
    import alu_exec_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  wire logic [XLEN-1:0] input1,
    input  wire logic [XLEN-1:0] input2,
    input  wire logic [3:0]      alu_operation,
    output logic      [XLEN-1:0] out,
    output logic                 zero,
    output logic                 negative
);
    logic [4:0] w_shamt;

    assign w_shamt = input2[4:0];

    always_comb begin
        out = '0;
        case (alu_operation)
            ALU_ADD:  out = input1 + input2;
            ALU_SUB:  out = input1 - input2;
            ALU_AND:  out = input1 & input2;
            ALU_OR:   out = input1 | input2;
            ALU_XOR:  out = input1 ^ input2;
            ALU_NOR:  out = ~(input1 | input2);
            ALU_SLT:  out = {{(XLEN-1){1'b0}}, ($signed(input1) < $signed(input2))};
            ALU_SLTU: out = {{(XLEN-1){1'b0}}, (input1 < input2)};
            ALU_SLL:  out = input1 << w_shamt;
            ALU_SRL:  out = input1 >> w_shamt;
            ALU_SRA:  out = $unsigned($signed(input1) >>> w_shamt);
            ALU_LUI:  out = input2 << 16;
            ALU_MUL:  out = input1 * input2;
            ALU_PASS: out = input2;
            default:  out = '0;
        endcase
    end

    assign zero     = (out == '0);
    assign negative = out[XLEN-1];
endmodule : alu_core
`default_nettype wire

// File: rtl/alu_exec_unit.sv
`default_nettype none
// ============================================================================
//  Module      : alu_exec_unit
//  Description : Registered execute stage. This block selects the second
//                operand, runs the ALU and computes the branch target. All
//                results appear one cycle after valid_in is seen.
//                clk   : rising-edge clock
//                rst_b : synchronous active-high reset
//                bus   : operands/controls in, results/valid_out out
//  Revision    : 1.0  initial release
// ============================================================================
module alu_exec_unit
    import alu_exec_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  wire logic     clk,
    input  wire logic     rst_b,
    alu_exec_unit_if.slave bus
);
    logic [XLEN-1:0] w_imm;
    logic [XLEN-1:0] w_pre;
    logic [XLEN-1:0] w_input2;
    logic [XLEN-1:0] w_branch_off;
    logic [XLEN-1:0] w_alu_out;
    logic            w_zero;
    logic            w_negative;
    logic            w_unused_inst_bits;

    logic [XLEN-1:0] r_result;
    logic            r_zero;
    logic            r_negative;
    logic [XLEN-1:0] r_branch_target;
    logic            r_valid_out;

    assign w_imm = bus.is_unsigned ? {{(XLEN-16){1'b0}}, bus.inst[15:0]}
                                   : {{(XLEN-16){bus.inst[15]}}, bus.inst[15:0]};
    assign w_pre = bus.alu_src ? w_imm : bus.rt_data;

    // The shift-amount select sits last in the chain so it overrides both
    // the register and the immediate source.
    assign w_input2 = bus.does_shift_amount_need ? {{(XLEN-5){1'b0}}, bus.inst[10:6]}
                                                 : w_pre;

    // The branch offset is always sign-extended, even for unsigned-immediate ops.
    assign w_branch_off = {{(XLEN-18){bus.inst[15]}}, bus.inst[15:0], 2'b00};

    assign w_unused_inst_bits = ^{bus.inst[XLEN-1:16], bus.inst[5:0]};

    alu_core #(
        .XLEN (XLEN)
    ) u_alu_core (
        .input1        (bus.rs_data),
        .input2        (w_input2),
        .alu_operation (bus.alu_operation),
        .out           (w_alu_out),
        .zero          (w_zero),
        .negative      (w_negative)
    );

    always_ff @(posedge clk) begin
        if (rst_b) begin
            r_result        <= '0;
            r_zero          <= 1'b0;
            r_negative      <= 1'b0;
            r_branch_target <= '0;
            r_valid_out     <= 1'b0;
        end else begin
            r_valid_out <= bus.valid_in;
            if (bus.valid_in) begin
                r_result        <= w_alu_out;
                r_zero          <= w_zero;
                r_negative      <= w_negative;
                r_branch_target <= bus.pc_incremented + w_branch_off;
            end
        end
    end

    assign bus.result        = r_result;
    assign bus.zero          = r_zero;
    assign bus.negative      = r_negative;
    assign bus.branch_target = r_branch_target;
    assign bus.valid_out     = r_valid_out;
endmodule : alu_exec_unit
`default_nettype wire

// File: tb/tb_alu_exec_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_exec_unit
//  Description : Self-checking bench for alu_exec_unit: directed vectors
//                followed by random ones, compared against a behavioural model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_alu_exec_unit;
    import alu_exec_pkg::*;

    logic clk;
    logic rst_b;

    int n_vec;
    int n_err;

    logic [31:0] exp_result;
    logic        exp_zero;
    logic        exp_negative;
    logic [31:0] exp_bt;
    logic        exp_valid;

    alu_exec_unit_if #(.XLEN(32)) bus ();

    alu_exec_unit #(.XLEN(32)) dut (
        .clk   (clk),
        .rst_b (rst_b),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference ALU written directly from the operation table.
    function automatic logic [31:0] ref_alu(input int op, input logic [31:0] a, input logic [31:0] b);
        int signed sa;
        int signed sb;
        sa = a;
        sb = b;
        case (op)
            0:  return a + b;
            1:  return a - b;
            2:  return a & b;
            3:  return a | b;
            4:  return a ^ b;
            5:  return ~(a | b);
            6:  return (sa < sb) ? 32'd1 : 32'd0;
            7:  return (a < b) ? 32'd1 : 32'd0;
            8:  return a << b[4:0];
            9:  return a >> b[4:0];
            10: return sa >>> b[4:0];
            11: return {b[15:0], 16'h0000};
            12: return a * b;
            13: return b;
            default: return 32'd0;
        endcase
    endfunction

    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] rs,
                         input logic [31:0] rt, input logic [31:0] pc, input logic src,
                         input logic uns, input logic shf, input logic [3:0] op);
        bus.valid_in               = v;
        bus.inst                   = ins;
        bus.rs_data                = rs;
        bus.rt_data                = rt;
        bus.pc_incremented         = pc;
        bus.alu_src                = src;
        bus.is_unsigned            = uns;
        bus.does_shift_amount_need = shf;
        bus.alu_operation          = op;
    endtask

    // Update the model from the inputs now presented, clock once, then
    // compare every output against the model.
    task automatic tick(input string tag);
        logic [31:0] imm;
        logic [31:0] op2;
        logic [31:0] r;
        int signed   off;
        if (rst_b) begin
            exp_result   = 0;
            exp_zero     = 0;
            exp_negative = 0;
            exp_bt       = 0;
            exp_valid    = 0;
        end else begin
            exp_valid = bus.valid_in;
            if (bus.valid_in) begin
                if (bus.is_unsigned) imm = {16'h0, bus.inst[15:0]};
                else                 imm = $unsigned(int'($signed(bus.inst[15:0])));
                if (bus.does_shift_amount_need) op2 = 32'(bus.inst[10:6]);
                else if (bus.alu_src)           op2 = imm;
                else                            op2 = bus.rt_data;
                r            = ref_alu(int'(bus.alu_operation), bus.rs_data, op2);
                exp_result   = r;
                exp_zero     = (r == 0);
                exp_negative = r[31];
                off          = int'($signed(bus.inst[15:0])) * 4;
                exp_bt       = bus.pc_incremented + $unsigned(off);
            end
        end
        @(posedge clk);
        #1;
        check_val({tag, ".result"}, bus.result, exp_result);
        check_val({tag, ".zero"}, 32'(bus.zero), 32'(exp_zero));
        check_val({tag, ".negative"}, 32'(bus.negative), 32'(exp_negative));
        check_val({tag, ".branch_target"}, bus.branch_target, exp_bt);
        check_val({tag, ".valid_out"}, 32'(bus.valid_out), 32'(exp_valid));
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        exp_result = 0; exp_zero = 0; exp_negative = 0; exp_bt = 0; exp_valid = 0;

        // Reset with valid_in asserted: reset must win.
        rst_b = 1'b1;
        drive(1, 32'h1234_5678, 32'd9, 32'd9, 32'h100, 0, 0, 0, ALU_ADD);
        @(posedge clk); #1;
        tick("reset1");
        tick("reset2");
        check_val("reset_result", bus.result, 32'd0);
        rst_b = 1'b0;

        drive(1, 32'h0, 32'd5, 32'd7, 32'h0, 0, 0, 0, ALU_ADD);
        tick("add_first");
        check_val("add_12", bus.result, 32'd12);

        // Immediate sign/zero extension.
        drive(1, 32'h0000_FFFF, 32'd1, 32'd0, 32'h0, 1, 0, 0, ALU_ADD);
        tick("imm_signed");
        check_val("imm_signed_zero", 32'(bus.zero), 32'd1);
        drive(1, 32'h0000_FFFF, 32'd1, 32'd0, 32'h0, 1, 1, 0, ALU_ADD);
        tick("imm_unsigned");
        check_val("imm_unsigned_val", bus.result, 32'h0001_0000);

        // Shift amount overrides the immediate source.
        drive(1, 32'd4 << 6, 32'h8000_0000, 32'd0, 32'h0, 1, 0, 1, ALU_SRA);
        tick("sra");
        check_val("sra_val", bus.result, 32'hF800_0000);
        drive(1, 32'd4 << 6, 32'h8000_0000, 32'd0, 32'h0, 1, 0, 1, ALU_SRL);
        tick("srl");
        check_val("srl_val", bus.result, 32'h0800_0000);

        // Signed vs unsigned compares and negative subtraction.
        drive(1, 32'h0, 32'hFFFF_FFFF, 32'd1, 32'h0, 0, 0, 0, ALU_SLT);
        tick("slt");
        check_val("slt_val", bus.result, 32'd1);
        drive(1, 32'h0, 32'hFFFF_FFFF, 32'd1, 32'h0, 0, 0, 0, ALU_SLTU);
        tick("sltu");
        drive(1, 32'h0, 32'd3, 32'd5, 32'h0, 0, 0, 0, ALU_SUB);
        tick("sub");
        check_val("sub_val", bus.result, 32'hFFFF_FFFE);

        // Branch target, negative and positive offsets.
        drive(1, 32'h0000_FFFF, 32'd0, 32'd0, 32'h104, 0, 1, 0, ALU_ADD);
        tick("bt_neg");
        check_val("bt_neg_val", bus.branch_target, 32'h0000_0100);
        drive(1, 32'h0000_0003, 32'd0, 32'd0, 32'h104, 0, 0, 0, ALU_ADD);
        tick("bt_pos");
        check_val("bt_pos_val", bus.branch_target, 32'h0000_0110);

        // Hold behaviour while valid_in is low.
        drive(1, 32'h0, 32'd5, 32'd7, 32'h40, 0, 0, 0, ALU_ADD);
        tick("hold_load");
        drive(0, 32'hFFFF_FFFF, 32'd100, 32'd200, 32'h80, 0, 0, 0, ALU_SUB);
        tick("hold");
        check_val("hold_val", bus.result, 32'd12);
        drive(1, 32'h0, 32'd5, 32'd7, 32'h0, 0, 0, 0, 4'd15);
        tick("op15");
        check_val("op15_zero", 32'(bus.zero), 32'd1);

        // Random traffic, with occasional mid-run resets.
        for (int i = 0; i < 400; i++) begin
            rst_b = ($urandom_range(0, 49) == 0);
            drive($urandom_range(0, 9) != 0, $urandom, $urandom, $urandom, $urandom,
                  1'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0),
                  4'($urandom_range(0, 15)));
            if ($urandom_range(0, 3) == 0) bus.rs_data = 32'($urandom_range(0, 3)) - 32'd2;
            tick("rand");
        end
        rst_b = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule : tb_alu_exec_unit
`default_nettype wire
